alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle issue/control unit that drives the CPU's combinational ALU. It accepts one
//  32-bit MIPS instruction plus register operands, decodes it to the 5-bit ALU op code, and
//  drives the ALU A/B operands. It captures the ALU result and zero flag, then presents a
//  registered writeback/branch response. It sits between the register-read stage and writeback.
// PARAMETERS
//  DATA_W      32       operand/result width; only 32 is supported
//  OP_W        5        ALU op-code width
//  ILLEGAL_OP  5'h1F    op code driven for undecodable instructions (ALU returns out=0, zero=0)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   instruction+operands valid
//  in_ready   out  1   high only in IDLE
//  in_instr   in   32  MIPS instruction word
//  in_rs      in   32  GPR[rs] value
//  in_rt      in   32  GPR[rt] value
//  alu_op     out  5   to ALU op
//  alu_a      out  32  to ALU A
//  alu_b      out  32  to ALU B
//  alu_out    in   32  from ALU out
//  alu_zero   in   1   from ALU zero
//  out_valid  out  1   response valid
//  out_ready  in   1   response accepted
//  res_data   out  32  ALU result
//  res_dst    out  5   destination register
//  res_wen    out  1   register write enable
//  res_branch out  1   instruction is beq/bne
//  res_taken  out  1   branch taken (=alu_zero captured)
//  res_illegal out 1   undecodable instruction
//  res_ovf    out  1   signed overflow (exists only with ALU_ISSUE_OVF_EN)
// BEHAVIOUR
//  - Reset: FSM=IDLE; every output 0, except in_ready=1 and alu_op=ILLEGAL_OP. Reset is legal
//    in any state and aborts the operation in flight; nothing is replayed.
//  - FSM: IDLE -(in_valid)-> DECODE -> EXEC -> RESP -(out_ready)-> IDLE.
//    * IDLE: instruction and operands are registered on the handshake.
//    * DECODE: alu_op, alu_a and alu_b are registered; they hold until the next DECODE.
//    * EXEC: alu_out and alu_zero are sampled into the res_* registers.
//    * RESP: out_valid=1 and all res_* are stable until out_ready.
//  - Timing: out_valid rises 3 cycles after the accept edge. Best throughput is 1 instruction
//    per 4 cycles. A new accept is possible only on the cycle after the RESP handshake.
//  - Decode, R-type (opcode 0), by funct; A/B and dst=rd unless noted:
//      20 add 00000 | 21 addu 00001 | 22 sub 00010 | 23 subu 00011 | 24 and 00100
//      25 or 00101 | 26 xor 00110 | 27 nor 00111 | 2A slt 01000 | 2B sltu 01001
//      00 sll 01010 (A={27'b0,shamt}, B=rt) | 02 srl 01011 | 03 sra 01100 (same A/B as sll)
//      04 sllv 01010 | 06 srlv 01011 | 07 srav 01100 (A=rs, B=rt)
//  - Decode, I-type; A=rs, dst=rt, se=sign-extended imm, ze=zero-extended imm:
//      08 addi 00000 se | 09 addiu 00001 se | 0A slti 01000 se | 0B sltiu 01001 se
//      0C andi 00100 ze | 0D ori 00101 ze | 0E xori 00110 ze | 0F lui 01111 (B=ze, A=0)
//      04 beq 01101 (B=rt) | 05 bne 01110 (B=rt): res_branch=1, res_taken=zero, wen=0, dst=0
//  - All other encodings: alu_op=ILLEGAL_OP, res_illegal=1, wen=0, dst=0, data=0.
//  - res_wen=0 whenever dst==0. All arithmetic is modulo 2^32; no carry out.
// CONFIGURATION
//  ALU_ISSUE_OVF_EN defined:
//    - res_ovf port exists. For add/sub/addi it is computed at EXEC from operand and result
//      signs (add: a,b same sign, result differs; sub: a,b differ, result sign != a).
//    - When res_ovf=1: res_wen=0; res_data still shows alu_out.
//  ALU_ISSUE_OVF_EN undefined:
//    - No res_ovf port; overflow is never flagged and writeback is unconditional.
// TESTING
//  1. add $3,$1,$2: 0x00221820, rs=5, rt=7 -> op=00000, a=5, b=7; res_data=12, dst=3, wen=1;
//     out_valid 3 cycles after accept.
//  2. beq: 0x10220004, rs=rt=9 -> op=01101; branch=1, taken=1, wen=0. Repeat with rt=8 -> taken=0.
//  3. sll $2,$1,4: 0x00011100, rt=1 -> op=01010, a=4, b=1; res_data=16, dst=2.
//  4. lui $4,0x1234: 0x3C041234 -> op=01111, b=0x00001234; res_data=0x12340000, dst=4.
//  5. Hold out_ready=0 for 5 cycles in RESP -> response stable, in_ready=0. Assert rst_n=0 in
//     EXEC -> out_valid=0 immediately. Opcode 0x3F -> res_illegal=1, wen=0.
//  6. addi $2,$1,1: 0x20220001, rs=0x7FFFFFFF -> with macro: res_ovf=1, wen=0;
//     without macro: res_data=0x80000000, wen=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle MIPS issue/control unit for an external combinational ALU: IDLE->DECODE->EXEC->RESP.
// Optional signed-overflow reporting is built when ALU_ISSUE_OVF_EN is defined.
`timescale 1ns/1ps
module alu_issue_ctrl #(
  parameter int              DATA_W     = 32,
  parameter int              OP_W       = 5,
  parameter logic [OP_W-1:0] ILLEGAL_OP = 5'h1F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [4:0]        res_dst,
  output logic              res_wen,
  output logic              res_branch,
  output logic              res_taken,
  output logic              res_illegal
`ifdef ALU_ISSUE_OVF_EN
  ,output logic             res_ovf
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_RESP} state_t;

  localparam logic [OP_W-1:0] OP_ADD  = 5'h00, OP_ADDU = 5'h01, OP_SUB  = 5'h02, OP_SUBU = 5'h03;
  localparam logic [OP_W-1:0] OP_AND  = 5'h04, OP_OR   = 5'h05, OP_XOR  = 5'h06, OP_NOR  = 5'h07;
  localparam logic [OP_W-1:0] OP_SLT  = 5'h08, OP_SLTU = 5'h09, OP_SLL  = 5'h0A, OP_SRL  = 5'h0B;
  localparam logic [OP_W-1:0] OP_SRA  = 5'h0C, OP_BEQ  = 5'h0D, OP_BNE  = 5'h0E, OP_LUI  = 5'h0F;

  state_t state_q, state_d;

  logic [31:0]       instr_q;
  logic [DATA_W-1:0] rs_q, rt_q;
  logic [OP_W-1:0]   alu_op_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [4:0]        dst_q;
  logic              br_q, ill_q;

  logic [DATA_W-1:0] res_data_q;
  logic [4:0]        res_dst_q;
  logic              res_wen_q, res_branch_q, res_taken_q, res_illegal_q;

  logic [OP_W-1:0]   dec_op;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic [4:0]        dec_dst;
  logic              dec_br, dec_ill;
  logic              wb_block;

  logic [5:0]  opcode, funct;
  logic [4:0]  rt_idx, rd_idx, shamt;
  logic [15:0] imm;
  assign opcode = instr_q[31:26];
  assign rt_idx = instr_q[20:16];
  assign rd_idx = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];
  assign imm    = instr_q[15:0];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = S_RESP;
      S_RESP:   if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_RESP);
  end

  always_comb begin
    dec_op  = ILLEGAL_OP;
    dec_a   = rs_q;
    dec_b   = rt_q;
    dec_dst = rd_idx;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20: dec_op = OP_ADD;
          6'h21: dec_op = OP_ADDU;
          6'h22: dec_op = OP_SUB;
          6'h23: dec_op = OP_SUBU;
          6'h24: dec_op = OP_AND;
          6'h25: dec_op = OP_OR;
          6'h26: dec_op = OP_XOR;
          6'h27: dec_op = OP_NOR;
          6'h2A: dec_op = OP_SLT;
          6'h2B: dec_op = OP_SLTU;
          6'h00: begin dec_op = OP_SLL; dec_a = {{(DATA_W-5){1'b0}}, shamt}; end
          6'h02: begin dec_op = OP_SRL; dec_a = {{(DATA_W-5){1'b0}}, shamt}; end
          6'h03: begin dec_op = OP_SRA; dec_a = {{(DATA_W-5){1'b0}}, shamt}; end
          6'h04: dec_op = OP_SLL;
          6'h06: dec_op = OP_SRL;
          6'h07: dec_op = OP_SRA;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h08: begin dec_op = OP_ADD;  dec_b = {{16{imm[15]}}, imm}; dec_dst = rt_idx; end
      6'h09: begin dec_op = OP_ADDU; dec_b = {{16{imm[15]}}, imm}; dec_dst = rt_idx; end
      6'h0A: begin dec_op = OP_SLT;  dec_b = {{16{imm[15]}}, imm}; dec_dst = rt_idx; end
      6'h0B: begin dec_op = OP_SLTU; dec_b = {{16{imm[15]}}, imm}; dec_dst = rt_idx; end
      6'h0C: begin dec_op = OP_AND;  dec_b = {16'h0, imm}; dec_dst = rt_idx; end
      6'h0D: begin dec_op = OP_OR;   dec_b = {16'h0, imm}; dec_dst = rt_idx; end
      6'h0E: begin dec_op = OP_XOR;  dec_b = {16'h0, imm}; dec_dst = rt_idx; end
      6'h0F: begin dec_op = OP_LUI;  dec_a = '0; dec_b = {16'h0, imm}; dec_dst = rt_idx; end
      6'h04: begin dec_op = OP_BEQ;  dec_br = 1'b1; dec_dst = 5'd0; end
      6'h05: begin dec_op = OP_BNE;  dec_br = 1'b1; dec_dst = 5'd0; end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_op  = ILLEGAL_OP;
      dec_a   = '0;
      dec_b   = '0;
      dec_dst = 5'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
    end else if (state_q == S_IDLE && in_valid) begin
      instr_q <= in_instr;
      rs_q    <= in_rs;
      rt_q    <= in_rt;
    end
  end

  // ALU drive registers hold from one DECODE to the next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op_q <= ILLEGAL_OP;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      dst_q    <= '0;
      br_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else if (state_q == S_DECODE) begin
      alu_op_q <= dec_op;
      alu_a_q  <= dec_a;
      alu_b_q  <= dec_b;
      dst_q    <= dec_dst;
      br_q     <= dec_br;
      ill_q    <= dec_ill;
    end
  end

`ifdef ALU_ISSUE_OVF_EN
  logic ovf_add_q, ovf_sub_q, ovf_now, res_ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_add_q <= 1'b0;
      ovf_sub_q <= 1'b0;
    end else if (state_q == S_DECODE) begin
      ovf_add_q <= (opcode == 6'h08) || (opcode == 6'h00 && funct == 6'h20);
      ovf_sub_q <= (opcode == 6'h00 && funct == 6'h22);
    end
  end
  assign ovf_now = (ovf_add_q && (alu_a_q[DATA_W-1] == alu_b_q[DATA_W-1]) &&
                    (alu_out[DATA_W-1] != alu_a_q[DATA_W-1])) ||
                   (ovf_sub_q && (alu_a_q[DATA_W-1] != alu_b_q[DATA_W-1]) &&
                    (alu_out[DATA_W-1] != alu_a_q[DATA_W-1]));
  assign wb_block = ovf_now;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 res_ovf_q <= 1'b0;
    else if (state_q == S_EXEC) res_ovf_q <= ovf_now;
  end
  assign res_ovf = res_ovf_q;
`else
  assign wb_block = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data_q    <= '0;
      res_dst_q     <= '0;
      res_wen_q     <= 1'b0;
      res_branch_q  <= 1'b0;
      res_taken_q   <= 1'b0;
      res_illegal_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      res_data_q    <= ill_q ? '0 : alu_out;
      res_dst_q     <= dst_q;
      res_wen_q     <= (dst_q != 5'd0) && !br_q && !ill_q && !wb_block;
      res_branch_q  <= br_q;
      res_taken_q   <= br_q && alu_zero;
      res_illegal_q <= ill_q;
    end
  end

  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign res_data    = res_data_q;
  assign res_dst     = res_dst_q;
  assign res_wen     = res_wen_q;
  assign res_branch  = res_branch_q;
  assign res_taken   = res_taken_q;
  assign res_illegal = res_illegal_q;

endmodule
